// File: rtl/shiftreg_pkg.sv
// Shared types for the shiftreg_seq register: shift modes and sequencer states.
package shiftreg_pkg;

    // Shift mode encoding matches the MODE input pins.
    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROL = 2'b11
    } shift_mode_t;

    // Sequencer states; BUSY is simply "not IDLE".
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FIN   = 2'b10
    } state_t;

endpackage

// File: rtl/shiftreg_seq_shift_step.sv
// shift_step: combinational single-bit shifter used by both the sequence
// path and the idle SH path. out_bit is the bit that leaves the register.
module shift_step
    import shiftreg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q,
    input  shift_mode_t  mode,
    input  logic         fill,
    output logic [N-1:0] q_next,
    output logic         out_bit
);

    // One step in the selected direction, reporting the departing bit.
    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (mode)
            LSL: begin
                q_next  = {q[N-2:0], fill};
                out_bit = q[N-1];
            end
            LSR: begin
                q_next  = {fill, q[N-1:1]};
                out_bit = q[0];
            end
            ASR: begin
                q_next  = {q[N-1], q[N-1:1]};
                out_bit = q[0];
            end
            ROL: begin
                q_next  = {q[N-2:0], q[N-1]};
                out_bit = q[N-1];
            end
            default: begin
                q_next  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shiftreg_seq.sv
// shiftreg_seq: load/left-shift register with a START/BUSY/DONE multi-cycle
// shift sequencer (LSL, LSR, ASR, ROL by 0..2^AMT_W-1 steps).
// Optional macro SHIFTREG_SEQ_CARRY_EN adds the CO carry-out port.
//
// Handshake: START is accepted only while BUSY is low; at that edge D, MODE,
// AMT and SER_IN are captured. BUSY stays high until the sequence finishes and
// DONE pulses for exactly one cycle (the last BUSY cycle). While BUSY, all
// control and data inputs are ignored.
module shiftreg_seq
    import shiftreg_pkg::*;
#(
    parameter int N     = 8,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N-1:0]     D,
    input  logic             LD,
    input  logic             SH,
    input  logic             SER_IN,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [AMT_W-1:0] AMT,
    output logic [N-1:0]     Q,
    output logic             BUSY,
    output logic             DONE
`ifdef SHIFTREG_SEQ_CARRY_EN
    ,
    output logic             CO
`endif
);

    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
    localparam logic [AMT_W-1:0] CNT_ZERO = '0;

    state_t           state;
    logic [AMT_W-1:0] count;
    shift_mode_t      mode_r;
    logic             fill_r;

    shift_mode_t      step_mode;
    logic             step_fill;
    logic [N-1:0]     step_q;
    logic             step_out;

    // Idle SH is always a left shift filled from SER_IN; sequences use the latched mode/fill.
    always_comb begin
        step_mode = mode_r;
        step_fill = fill_r;
        if (state == IDLE) begin
            step_mode = LSL;
            step_fill = SER_IN;
        end
    end

    shift_step #(.N(N)) u_step (
        .q       (Q),
        .mode    (step_mode),
        .fill    (step_fill),
        .q_next  (step_q),
        .out_bit (step_out)
    );

`ifndef SHIFTREG_SEQ_CARRY_EN
    logic unused_carry;
    assign unused_carry = step_out;
`endif

    assign BUSY = (state != IDLE);

    // Sequencer, data register and registered DONE pulse; reset abandons any sequence.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= IDLE;
            Q      <= '0;
            count  <= '0;
            mode_r <= LSL;
            fill_r <= 1'b0;
            DONE   <= 1'b0;
`ifdef SHIFTREG_SEQ_CARRY_EN
            CO     <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        Q      <= D;
                        mode_r <= shift_mode_t'(MODE);
                        fill_r <= SER_IN;
                        count  <= AMT;
`ifdef SHIFTREG_SEQ_CARRY_EN
                        CO     <= 1'b0;
`endif
                        if (AMT == CNT_ZERO) begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end else if (LD) begin
                        Q <= D;
                    end else if (SH) begin
                        Q  <= step_q;
`ifdef SHIFTREG_SEQ_CARRY_EN
                        CO <= step_out;
`endif
                    end
                end
                SHIFT: begin
                    Q     <= step_q;
`ifdef SHIFTREG_SEQ_CARRY_EN
                    CO    <= step_out;
`endif
                    count <= count - CNT_ONE;
                    if (count <= CNT_ONE) begin
                        state <= FIN;
                        DONE  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_seq.sv
// Bench for shiftreg_seq (N=8, AMT_W=4): directed steps followed by random
// sequences and idle operations, compared against an arithmetic reference.
module tb_shiftreg_seq;

    localparam int N     = 8;
    localparam int AMT_W = 4;

    logic             CLK;
    logic             RST_N;
    logic [N-1:0]     D;
    logic             LD;
    logic             SH;
    logic             SER_IN;
    logic             START;
    logic [1:0]       MODE;
    logic [AMT_W-1:0] AMT;
    logic [N-1:0]     Q;
    logic             BUSY;
    logic             DONE;
`ifdef SHIFTREG_SEQ_CARRY_EN
    logic             CO;
`endif

    int checks = 0;
    int errors = 0;

    logic [N-1:0] q_model;
    logic         co_model;

    shiftreg_seq #(.N(N), .AMT_W(AMT_W)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .D      (D),
        .LD     (LD),
        .SH     (SH),
        .SER_IN (SER_IN),
        .START  (START),
        .MODE   (MODE),
        .AMT    (AMT),
        .Q      (Q),
        .BUSY   (BUSY),
        .DONE   (DONE)
`ifdef SHIFTREG_SEQ_CARRY_EN
        ,
        .CO     (CO)
`endif
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_co(input string tag);
`ifdef SHIFTREG_SEQ_CARRY_EN
        chk(tag, 32'(CO), 32'(co_model));
`else
        if (tag.len() == 0) $display("empty carry tag");
`endif
    endtask

    // Reference result of shifting d by k steps in the given mode.
    function automatic logic [N-1:0] ref_q(input logic [N-1:0] d, input int mode,
                                           input int k, input logic fill);
        int v;
        logic signed [N-1:0] s;
        v = 0;
        case (mode)
            0: begin
                if (k >= N) v = fill ? (1 << N) - 1 : 0;
                else v = (int'(d) << k) | (fill ? ((1 << k) - 1) : 0);
            end
            1: begin
                if (k >= N) v = fill ? (1 << N) - 1 : 0;
                else v = (int'(d) >> k) | (fill ? ((((1 << N) - 1) << (N - k)) & ((1 << N) - 1)) : 0);
            end
            2: begin
                s = d;
                s = s >>> k;
                v = int'(s) & ((1 << N) - 1);
            end
            default: begin
                v = ((int'(d) << (k % N)) | (int'(d) >> (N - (k % N)))) & ((1 << N) - 1);
            end
        endcase
        return v[N-1:0];
    endfunction

    // Reference for the last bit to leave the register during a k-step sequence.
    function automatic logic ref_co(input logic [N-1:0] d, input int mode,
                                    input int k, input logic fill);
        if (k == 0) return 1'b0;
        case (mode)
            0:       return (k <= N) ? d[N-k] : fill;
            1:       return (k <= N) ? d[k-1] : fill;
            2:       return (k <= N) ? d[k-1] : d[N-1];
            default: return d[(N - (k % N)) % N];
        endcase
    endfunction

    // Random activity on every input while busy; none of it may have an effect.
    task automatic noise();
        START  = 1'($urandom_range(0, 1));
        LD     = 1'($urandom_range(0, 1));
        SH     = 1'($urandom_range(0, 1));
        SER_IN = 1'($urandom_range(0, 1));
        D      = N'($urandom);
        MODE   = 2'($urandom_range(0, 3));
        AMT    = AMT_W'($urandom_range(0, 15));
    endtask

    task automatic quiet();
        START = 1'b0;
        LD    = 1'b0;
        SH    = 1'b0;
    endtask

    // Issue one START and follow it cycle by cycle through BUSY/DONE.
    task automatic run_seq(input string tag, input logic [N-1:0] d, input int mode,
                           input int amt, input logic fill);
        int busy_cycles;
        @(negedge CLK);
        START = 1'b1; LD = 1'b0; SH = 1'b0;
        D = d; MODE = 2'(mode); AMT = AMT_W'(amt); SER_IN = fill;
        busy_cycles = (amt == 0) ? 1 : amt + 1;
        q_model  = ref_q(d, mode, amt, fill);
        co_model = ref_co(d, mode, amt, fill);
        for (int c = 1; c <= busy_cycles; c++) begin
            @(negedge CLK);
            noise();
            chk({tag, " busy"}, 32'(BUSY), 32'd1);
            chk({tag, " done"}, 32'(DONE), (c == busy_cycles) ? 32'd1 : 32'd0);
        end
        chk({tag, " q_fin"}, 32'(Q), 32'(q_model));
        chk_co({tag, " co_fin"});
        @(negedge CLK);
        quiet();
        chk({tag, " idle_busy"}, 32'(BUSY), 32'd0);
        chk({tag, " idle_done"}, 32'(DONE), 32'd0);
        chk({tag, " q_hold"}, 32'(Q), 32'(q_model));
    endtask

    // One idle-cycle LD/SH operation with the model applying the same priority.
    task automatic idle_op(input string tag, input logic ld, input logic sh,
                           input logic [N-1:0] d, input logic ser);
        @(negedge CLK);
        START = 1'b0; LD = ld; SH = sh; D = d; SER_IN = ser;
        if (ld) begin
            q_model = d;
        end else if (sh) begin
            co_model = q_model[N-1];
            q_model  = N'((int'(q_model) << 1) | int'(ser));
        end
        @(negedge CLK);
        quiet();
        chk({tag, " q"}, 32'(Q), 32'(q_model));
        chk({tag, " busy"}, 32'(BUSY), 32'd0);
        chk_co({tag, " co"});
    endtask

    initial begin
        RST_N = 1'b0;
        D = '0; LD = 1'b0; SH = 1'b0; SER_IN = 1'b0; START = 1'b0; MODE = '0; AMT = '0;
        q_model = '0;
        co_model = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset q", 32'(Q), 32'h0);
        chk("reset busy", 32'(BUSY), 32'd0);
        chk("reset done", 32'(DONE), 32'd0);
        chk_co("reset co");
        RST_N = 1'b1;

        // 1: reset in the middle of an LSL by 5, after two shifts.
        @(negedge CLK);
        START = 1'b1; D = 8'h81; MODE = 2'd0; AMT = 4'd5; SER_IN = 1'b0;
        @(negedge CLK);
        quiet();
        chk("t1 busy0", 32'(BUSY), 32'd1);
        repeat (2) @(negedge CLK);
        chk("t1 two_shifts", 32'(Q), 32'h04);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        q_model = '0;
        co_model = 1'b0;
        chk("t1 rst_q", 32'(Q), 32'h0);
        chk("t1 rst_busy", 32'(BUSY), 32'd0);
        chk("t1 rst_done", 32'(DONE), 32'd0);
        chk_co("t1 rst_co");
        run_seq("t1 restart", 8'h3C, 1, 2, 1'b0);

        // 2..5: directed sequences from the test plan.
        run_seq("t2 lsl3", 8'h81, 0, 3, 1'b0);
        chk("t2 value", 32'(Q), 32'h08);
        run_seq("t3 asr2", 8'h90, 2, 2, 1'b0);
        chk("t3 asr value", 32'(Q), 32'hE4);
        run_seq("t3 lsr2", 8'h90, 1, 2, 1'b1);
        chk("t3 lsr value", 32'(Q), 32'hE4);
        run_seq("t4 rol9", 8'hA5, 3, 9, 1'b0);
        chk("t4 value", 32'(Q), 32'h4B);
        run_seq("t5 amt0", 8'h5A, 0, 0, 1'b1);
        chk("t5 value", 32'(Q), 32'h5A);
        run_seq("lsl15 sat", 8'hFF, 0, 15, 1'b1);
        run_seq("asr15 sat", 8'h80, 2, 15, 1'b0);
        run_seq("lsr8", 8'hC3, 1, 8, 1'b0);

        // 6: idle LD beats SH, then serial left shifts.
        idle_op("t6 ld_sh", 1'b1, 1'b1, 8'h3C, 1'b0);
        idle_op("t6 sh1", 1'b0, 1'b1, 8'h00, 1'b1);
        chk("t6 q79", 32'(Q), 32'h79);
        idle_op("t6 sh0a", 1'b0, 1'b1, 8'hFF, 1'b0);
        idle_op("t6 sh0b", 1'b0, 1'b1, 8'hFF, 1'b0);
        chk("t6 qE4", 32'(Q), 32'hE4);
        idle_op("hold", 1'b0, 1'b0, 8'h99, 1'b1);

        // Random sequences interleaved with random idle operations.
        for (int i = 0; i < 40; i++) begin
            run_seq("rand seq", N'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            idle_op("rand idle", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    N'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
